// File: rtl/p_hit_calc.sv
// p_hit_calc
//   Producer end of the p_hit stream. Pops one ray record (origin, dir, t) from an
//   upstream first-word-fall-through FIFO. Computes p_hit = origin + t*dir per
//   component in signed Q(32-Q_BITS).Q_BITS fixed point. Pushes the 3-component
//   result into the downstream FIFO.
//   The design is a two-stage pipeline that delivers one result per clock when unstalled.
//
// Ports
//   clock      : single clock, all state updates on posedge
//   reset      : asynchronous, active-high; discards in-flight records
//   origin     : ray origin x,y,z (index 0..2), signed 32-bit
//   dir        : ray direction x,y,z, signed 32-bit
//   t          : ray parameter at hit, signed 32-bit
//   in_empty   : input FIFO empty
//   in_rd_en   : pop input FIFO this cycle
//   p_hit_out  : hit point x,y,z, drives downstream FIFO din
//   out_wr_en  : push p_hit_out this cycle
//   out_full   : output FIFO full
module p_hit_calc #(
  parameter int unsigned Q_BITS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0][31:0] origin,
  input  logic [2:0][31:0] dir,
  input  logic [31:0]      t,
  input  logic             in_empty,
  output logic             in_rd_en,
  output logic [2:0][31:0] p_hit_out,
  output logic             out_wr_en,
  input  logic             out_full
);

  logic             s1_valid;
  logic             s2_valid;
  logic [2:0][63:0] prod;
  logic [2:0][31:0] org;
  logic             stall;
  logic             advance;

  // The whole pipe freezes only when a finished word cannot leave.
  // The pipe never compresses bubbles. The control stays a single gate deep.
  assign stall     = s2_valid & out_full;
  assign advance   = ~stall;
  assign out_wr_en = s2_valid & ~out_full;
  assign in_rd_en  = ~in_empty & advance;

  // Stage 1: full 64-bit signed product dir*t (low 64 bits of sign-extended operands)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      prod     <= '0;
      org      <= '0;
    end else if (advance) begin
      s1_valid <= in_rd_en;
      if (in_rd_en) begin
        for (int unsigned i = 0; i < 3; i++) begin
          prod[i] <= {{32{dir[i][31]}}, dir[i]} * {{32{t[31]}}, t};
          org[i]  <= origin[i];
        end
      end
    end
  end

  // Stage 2: re-align product to Q_BITS (arithmetic shift via slice) and add, wrapping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      p_hit_out <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        for (int unsigned i = 0; i < 3; i++) begin
          p_hit_out[i] <= org[i] + prod[i][Q_BITS+31:Q_BITS];
        end
      end
    end
  end

endmodule

// File: tb/tb_p_hit_calc.sv
module tb_p_hit_calc;

  localparam int unsigned Q = 16;

  typedef struct packed {
    logic [2:0][31:0] o;
    logic [2:0][31:0] d;
    logic [31:0]      t;
  } rec_t;

  logic             clock = 1'b0;
  logic             reset;
  logic [2:0][31:0] origin;
  logic [2:0][31:0] dir;
  logic [31:0]      t;
  logic             in_empty;
  logic             in_rd_en;
  logic [2:0][31:0] p_hit_out;
  logic             out_wr_en;
  logic             out_full;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  int pushes = 0;
  bit saw_push;
  logic [2:0][31:0] exp_q[$];

  always #5 clock = ~clock;

  p_hit_calc #(.Q_BITS(Q)) dut (
    .clock     (clock),
    .reset     (reset),
    .origin    (origin),
    .dir       (dir),
    .t         (t),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .p_hit_out (p_hit_out),
    .out_wr_en (out_wr_en),
    .out_full  (out_full)
  );

  // Reference: real-valued fixed-point product, floor-shifted, 32-bit wrapping add
  function automatic logic [2:0][31:0] model(input rec_t r);
    logic [2:0][31:0] res;
    longint p;
    for (int i = 0; i < 3; i++) begin
      p = longint'($signed(r.d[i])) * longint'($signed(r.t));
      res[i] = r.o[i] + 32'(p >>> Q);
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic rec_t rand_rec();
    rec_t r;
    for (int i = 0; i < 3; i++) begin
      r.o[i] = $urandom;
      r.d[i] = $urandom;
    end
    r.t = $urandom;
    return r;
  endfunction

  // One clock: drive at negedge, observe shortly after, scoreboard pops and pushes.
  task automatic cyc(input rec_t r, input bit empty, input bit full);
    @(negedge clock);
    {origin, dir, t} = r;
    in_empty = empty;
    out_full = full;
    #1;
    saw_push = out_wr_en;
    if (empty) check("rd_while_empty", {95'd0, in_rd_en}, 96'd0);
    if (full)  check("wr_while_full", {95'd0, out_wr_en}, 96'd0);
    if (out_wr_en) begin
      pushes++;
      if (exp_q.size() == 0) check("spurious_push", 96'd1, 96'd0);
      else check("p_hit", p_hit_out, exp_q.pop_front());
    end
    if (in_rd_en) begin
      pops++;
      exp_q.push_back(model(r));
    end
  endtask

  task automatic idle();
    cyc(rand_rec(), 1'b1, 1'b0);
  endtask

  rec_t r;
  logic [2:0][31:0] held;
  int n;

  initial begin
    reset = 1'b1; in_empty = 1'b1; out_full = 1'b0;
    origin = '0; dir = '0; t = '0;
    repeat (2) @(negedge clock);
    #1;
    check("reset_rd_en", {95'd0, in_rd_en}, 96'd0);
    check("reset_wr_en", {95'd0, out_wr_en}, 96'd0);
    check("reset_p_hit", p_hit_out, 96'd0);
    @(negedge clock); reset = 1'b0;

    // 1: unit direction times 2.0, latency of two cycles after the pop cycle
    r.o = '0; r.d = {32'd0, 32'd0, 32'h10000}; r.t = 32'h20000;
    cyc(r, 1'b0, 1'b0);
    check("t1_popped", {95'd0, in_rd_en}, 96'd1);
    idle();
    check("t1_no_early_push", {95'd0, saw_push}, 96'd0);
    idle();
    check("t1_push_latency", {95'd0, saw_push}, 96'd1);
    check("t1_value", p_hit_out, {32'd0, 32'd0, 32'h20000});

    // 2: negative direction component
    r.o = {32'h60000, 32'd0, 32'h10000}; r.d = {32'd0, 32'h8000, 32'hFFFF8000}; r.t = 32'h30000;
    cyc(r, 1'b0, 1'b0); idle(); idle();
    check("t2_value", p_hit_out, {32'h60000, 32'h18000, 32'hFFFF8000});

    // 6: wrap on overflow, no saturation
    r.o = {32'd0, 32'd0, 32'h7FFF0000}; r.d = {32'd0, 32'd0, 32'h10000}; r.t = 32'h10000;
    cyc(r, 1'b0, 1'b0); idle(); idle();
    check("t6_wrap", p_hit_out, {32'd0, 32'd0, 32'h80000000});

    // 3: 256 back-to-back records, one push per clock once the pipe fills
    n = pushes;
    for (int i = 0; i < 256; i++) begin
      cyc(rand_rec(), 1'b0, 1'b0);
      if (i >= 2 && !saw_push) check("t3_throughput", 96'd0, 96'd1);
    end
    idle(); idle();
    check("t3_push_count", 96'(pushes - n), 96'd256);
    check("t3_drained", 96'(exp_q.size()), 96'd0);

    // 4: stall with a full pipe for 5 cycles
    for (int i = 0; i < 4; i++) cyc(rand_rec(), 1'b0, 1'b0);
    held = p_hit_out;
    for (int i = 0; i < 5; i++) begin
      cyc(rand_rec(), 1'b0, 1'b1);
      if (i == 0) held = p_hit_out;
      check("t4_no_pop", {95'd0, in_rd_en}, 96'd0);
      check("t4_hold", p_hit_out, held);
    end
    cyc(rand_rec(), 1'b0, 1'b0);
    check("t4_resume_push", {95'd0, saw_push}, 96'd1);
    for (int i = 0; i < 4; i++) cyc(rand_rec(), 1'b0, 1'b0);
    idle(); idle();
    check("t4_no_loss_dup", 96'(exp_q.size()), 96'd0);
    check("t4_pop_push_balance", 96'(pops), 96'(pushes));

    // Random bubbles and back-pressure
    for (int i = 0; i < 300; i++)
      cyc(rand_rec(), ($urandom_range(3) == 0), ($urandom_range(3) == 0));
    for (int i = 0; i < 4; i++) idle();
    check("rand_drained", 96'(exp_q.size()), 96'd0);

    // 5: reset with two records in flight
    cyc(rand_rec(), 1'b0, 1'b0);
    cyc(rand_rec(), 1'b0, 1'b0);
    @(negedge clock);
    in_empty = 1'b1; out_full = 1'b0;
    #1;
    check("t5_pending_push", {95'd0, out_wr_en}, 96'd1);
    #1 reset = 1'b1;
    #1;
    check("t5_wr_en_cleared", {95'd0, out_wr_en}, 96'd0);
    check("t5_p_hit_cleared", p_hit_out, 96'd0);
    exp_q.delete();
    @(negedge clock); reset = 1'b0;
    r.o = {32'h3, 32'h2, 32'h1}; r.d = {32'h30000, 32'h20000, 32'h10000}; r.t = 32'h10000;
    cyc(r, 1'b0, 1'b0);
    idle();
    check("t5_no_stale_push", {95'd0, saw_push}, 96'd0);
    idle();
    check("t5_first_after_reset", p_hit_out, {32'h30003, 32'h20002, 32'h10001});
    check("t5_drained", 96'(exp_q.size()), 96'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
